// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_pkg                                                 |
// | Purpose  : Shared types and constants for the BCD stopwatch: FSM state   |
// |            encoding, BCD digit width, digit moduli and the packed        |
// |            MM:SS.hh time record.                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int BCD_W     = 4;
  localparam int HUN_MOD   = 10;
  localparam int SEC_T_MOD = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // One full MM:SS.hh reading, most significant digit first.
  typedef struct packed {
    logic [BCD_W-1:0] min_t;
    logic [BCD_W-1:0] min_o;
    logic [BCD_W-1:0] sec_t;
    logic [BCD_W-1:0] sec_o;
    logic [BCD_W-1:0] hun_t;
    logic [BCD_W-1:0] hun_o;
  } bcd_time_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_digit_cnt                                                 |
// | Purpose  : Single BCD digit counter, modulo MOD, with synchronous clear  |
// |            and a combinational carry-out for same-cycle ripple.          |
// | Ports    : clk   - system clock                                          |
// |            rst_n - asynchronous active-low reset                         |
// |            inc   - advance the digit by one on this clk edge             |
// |            clr   - force the digit to zero (wins over inc)               |
// |            q     - current digit value, 0..MOD-1                         |
// |            carry - inc while at MOD-1; feeds the next digit's inc        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] C_LAST = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == C_LAST) ? '0 : r_q + BCD_W'(1);
    end
  end

  assign q     = r_q;
  assign carry = inc & (r_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stopwatch_bcd                                                 |
// | Purpose  : BCD stopwatch MM:SS.hh driven by the divided hundredths wave. |
// |            Start/stop, lap-freeze and clear via one-cycle pulses.        |
// | Ports    : clk, rst_n         - system clock, async active-low reset     |
// |            tick_clk           - hundredths square wave (rising = count)  |
// |            start_stop/lap/clear - one-cycle command pulses               |
// |            disp_*_t/_o        - registered BCD display digits            |
// |            running            - high in RUN and LAP                      |
// |            frozen             - high in LAP                              |
// |            wrap               - 1-cycle pulse on MAX_MIN:59.99 -> 0      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_clk,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  output logic [BCD_W-1:0] disp_min_t,
  output logic [BCD_W-1:0] disp_min_o,
  output logic [BCD_W-1:0] disp_sec_t,
  output logic [BCD_W-1:0] disp_sec_o,
  output logic [BCD_W-1:0] disp_hun_t,
  output logic [BCD_W-1:0] disp_hun_o,
  output logic             running,
  output logic             frozen,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] C_MAX_T = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] C_MAX_O = BCD_W'(MAX_MIN % 10);

  state_t    r_state;
  state_t    w_state_nxt;
  logic      r_tick_q;
  logic      r_wrap;
  bcd_time_t r_hold;
  bcd_time_t r_disp;
  bcd_time_t w_live;

  logic w_tick_edge;
  logic w_count_en;
  logic w_clr_cnt;
  logic w_latch_hold;
  logic w_hun_o_carry;
  logic w_hun_t_carry;
  logic w_sec_o_carry;
  logic w_sec_t_carry;
  logic w_min_o_carry;
  logic w_min_t_carry;
  logic w_at_max;
  logic w_min_inc;
  logic w_wrap_now;
  logic w_min_clr;

  // --------------------------------------------------------------------------
  // Tick edge detect: a tick_clk held high produces exactly one count.
  // --------------------------------------------------------------------------
  assign w_tick_edge = tick_clk & ~r_tick_q;

  // Counting is qualified by the state *before* any command on this edge, so
  // a tick coinciding with a start_stop that leaves RUN/LAP still counts and
  // one coinciding with entry into RUN does not.
  assign w_count_en = w_tick_edge & ((r_state == ST_RUN) | (r_state == ST_LAP));

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tick_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick_q <= tick_clk;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clr_cnt    = 1'b0;
    w_latch_hold = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_stop) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) begin
          w_state_nxt = ST_PAUSE;
        end else if (lap) begin
          w_state_nxt  = ST_LAP;
          w_latch_hold = 1'b1;
        end
      end
      ST_LAP: begin
        if (start_stop)  w_state_nxt = ST_PAUSE;
        else if (lap)    w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear) begin
          w_state_nxt = ST_IDLE;
          w_clr_cnt   = 1'b1;
        end else if (start_stop) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign running = (r_state == ST_RUN) | (r_state == ST_LAP);
  assign frozen  = (r_state == ST_LAP);

  // --------------------------------------------------------------------------
  // Live count: hundredths and seconds ripple carries through the chain.
  // --------------------------------------------------------------------------
  bcd_digit_cnt #(.MOD(HUN_MOD)) u_hun_o (
    .clk(clk), .rst_n(rst_n), .inc(w_count_en), .clr(w_clr_cnt),
    .q(w_live.hun_o), .carry(w_hun_o_carry)
  );

  bcd_digit_cnt #(.MOD(HUN_MOD)) u_hun_t (
    .clk(clk), .rst_n(rst_n), .inc(w_hun_o_carry), .clr(w_clr_cnt),
    .q(w_live.hun_t), .carry(w_hun_t_carry)
  );

  bcd_digit_cnt #(.MOD(10)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .inc(w_hun_t_carry), .clr(w_clr_cnt),
    .q(w_live.sec_o), .carry(w_sec_o_carry)
  );

  bcd_digit_cnt #(.MOD(SEC_T_MOD)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .inc(w_sec_o_carry), .clr(w_clr_cnt),
    .q(w_live.sec_t), .carry(w_sec_t_carry)
  );

  // Minutes are a plain decimal pair; the MAX_MIN compare turns the carry out
  // of the seconds into a clear of both minute digits instead of an increment.
  assign w_at_max   = (w_live.min_t == C_MAX_T) & (w_live.min_o == C_MAX_O);
  assign w_min_inc  = w_sec_t_carry & ~w_at_max;
  // The tens carry can only fire past 99 minutes, which the compare above
  // already prevents; folding it in keeps the count bounded regardless.
  assign w_wrap_now = (w_sec_t_carry & w_at_max) | w_min_t_carry;
  assign w_min_clr  = w_clr_cnt | w_wrap_now;

  bcd_digit_cnt #(.MOD(10)) u_min_o (
    .clk(clk), .rst_n(rst_n), .inc(w_min_inc), .clr(w_min_clr),
    .q(w_live.min_o), .carry(w_min_o_carry)
  );

  bcd_digit_cnt #(.MOD(10)) u_min_t (
    .clk(clk), .rst_n(rst_n), .inc(w_min_o_carry), .clr(w_min_clr),
    .q(w_live.min_t), .carry(w_min_t_carry)
  );

  // --------------------------------------------------------------------------
  // Lap hold, display mux and wrap pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_disp <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (w_latch_hold) r_hold <= w_live;
      r_disp <= (r_state == ST_LAP) ? r_hold : w_live;
      r_wrap <= w_wrap_now;
    end
  end

  assign disp_min_t = r_disp.min_t;
  assign disp_min_o = r_disp.min_o;
  assign disp_sec_t = r_disp.sec_t;
  assign disp_sec_o = r_disp.sec_o;
  assign disp_hun_t = r_disp.hun_t;
  assign disp_hun_o = r_disp.hun_o;
  assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Consumes the divided 1/100-second square wave produced by the clock-divider chain and accumulates elapsed time as BCD digits MM:SS.hh for the pseudo-terminal display.
- Start/stop, lap-freeze and clear are controlled by single-cycle command pulses.
- Sits between the hundredths divider and the display/terminal formatter; the whole block runs in the system clock domain.

Parameters:
- MAX_MIN, 59, highest minute value before the count wraps to 00:00.00 (legal range 1..99).

Ports:
- clk  in  1  system clock; the same clock that drives the dividers
- rst_n  in  1  asynchronous, active-low reset
- tick_clk  in  1  divided hundredths square wave, synchronous to clk; one count per rising edge
- start_stop  in  1  one-cycle command pulse: toggles run/pause
- lap  in  1  one-cycle command pulse: freezes/unfreezes the displayed value
- clear  in  1  one-cycle command pulse: zeroes the count while paused
- disp_min_t, disp_min_o  out  4 each  displayed minutes, BCD tens/ones
- disp_sec_t, disp_sec_o  out  4 each  displayed seconds, BCD tens/ones (tens 0..5)
- disp_hun_t, disp_hun_o  out  4 each  displayed hundredths, BCD tens/ones
- running  out  1  high in RUN and LAP
- frozen  out  1  high in LAP
- wrap  out  1  one-cycle pulse on the MAX_MIN:59.99 -> 00:00.00 transition

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst_n. While rst_n=0: all count and display digits=0, state=IDLE, tick_q=0, running=0, frozen=0, wrap=0.
- Edge detect: tick_q is a register of tick_clk; tick_edge = tick_clk & ~tick_q. A tick_clk held high counts once.
- Counting:
  - On the clk edge where tick_edge=1 and the current (pre-transition) state is RUN or LAP, the live count increments by 0.01 s.
  - The live count is visible one clk after that edge when not frozen.
  - Digit moduli: hun_o 10, hun_t 10, sec_o 10, sec_t 6, minutes MAX_MIN+1 (BCD).
  - Carry ripples combinationally within the same cycle.
- Wrap: at MAX_MIN:59.99 the next tick sets the count to 00:00.00, pulses wrap for exactly 1 cycle, and counting continues.
- FSM states IDLE, RUN, PAUSE, LAP (2-bit encoding):
  - IDLE: start_stop -> RUN. lap and clear ignored.
  - RUN: start_stop -> PAUSE. lap -> LAP, latching the live count into the display hold register at that edge.
  - LAP: lap -> RUN, display returns to live. start_stop -> PAUSE, display returns to live. Counting continues throughout LAP.
  - PAUSE: start_stop -> RUN. clear -> IDLE with the live count zeroed. lap ignored.
- Simultaneous commands:
  - PAUSE: clear beats start_stop.
  - RUN/LAP: start_stop beats lap. clear is ignored in RUN/LAP.
  - A tick_edge in the same cycle as a start_stop that leaves RUN/LAP still counts.
  - A tick_edge in the same cycle as a start_stop that enters RUN from PAUSE/IDLE does not count.
- Display mux: the disp_* outputs are registered. They show the hold register when state=LAP, otherwise the live count.
- Reset mid-count: asynchronous; all values zero immediately, no wrap pulse.
- Command pulses wider than one cycle are an input-contract violation. Each high cycle acts as a separate command; no protection is provided.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_LAP=3
  - BCD_W=4
  - digit modulus constants HUN_MOD=10, SEC_T_MOD=6
- One sub-module, bcd_digit_cnt:
  - parameter MOD
  - ports clk, rst_n, inc, clr, q[3:0], carry
  - carry = inc & (q==MOD-1)
  - Instantiated four times for hundredths and seconds.
  - Minutes use a two-digit instance pair with a MAX_MIN compare for wrap.

Test Plan:
- Reset/idle: rst_n low 5 cycles, then 20 tick_clk rising edges with no command -> all digits 0, running=0, frozen=0, wrap=0 throughout.
- Basic count: start_stop pulse, then 123 tick_clk rising edges -> display 00:01.23, running=1. tick_clk held high 50 cycles counts exactly 1.
- Pause/clear priority:
  - start_stop after 250 ticks -> PAUSE at 00:02.50; further ticks ignored.
  - Assert start_stop and clear in the same cycle -> IDLE, 00:00.00, running=0.
- Lap freeze:
  - RUN at 00:05.00, lap pulse -> frozen=1, display holds 00:05.00 while 300 more ticks arrive.
  - Second lap -> display 00:08.00, frozen=0.
- Wrap: MAX_MIN=1, run to 01:59.99, one tick -> 00:00.00, wrap high exactly 1 cycle, counting continues to 00:00.01.
- Async reset mid-run: run to 00:00.37, drop rst_n between clk edges -> outputs zero before next clk edge. Release rst_n -> IDLE, no wrap pulse.
